// File: rtl/pipe_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types and defaults for the pipeline stall      |
// |                 sequencer                                            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    IMEM_WAIT = 2'd2,
    HALT      = 2'd3
  } pipe_state_t;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;

endpackage

`default_nettype wire

// File: rtl/pipe_wait_timer.sv
// +----------------------------------------------------------------------+
// | pipe_wait_timer : memory-wait cycle counter with expiry detection     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_wait_timer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              expire
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] SAT   = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Saturates at MAX_WAIT so the count can never wrap back into range.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (en && (wait_cnt_q != SAT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt = wait_cnt_q;
  assign expire   = en && (wait_cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// +----------------------------------------------------------------------+
// | pipeline_stall_ctrl : merges hazard and memory-wait requests into     |
// |                       per-stage stall/flush controls with timeout.    |
// | Optional macro PIPE_PERF_CNT_EN builds the stall/flush counters.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lu_hazard,
  input  logic             br_taken_ex,
  input  logic             imem_ack,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  pipe_state_t state_q, state_d;
  logic        drop_fetch_q, drop_fetch_d;
  logic        mem_err_q, mem_err_d;

  logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb;
  logic br_flush;
  logic dmem_stall;
  logic expire;
  logic [WAIT_W-1:0] wait_cnt_unused;

  assign dmem_stall = dmem_req && !dmem_ack;

  always_comb begin
    state_d      = state_q;
    drop_fetch_d = drop_fetch_q;
    mem_err_d    = mem_err_q;
    s_if         = 1'b0;
    s_id         = 1'b0;
    s_ex         = 1'b0;
    s_mem        = 1'b0;
    f_id         = 1'b0;
    f_ex         = 1'b0;
    f_wb         = 1'b0;
    br_flush     = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_stall) begin
          {s_if, s_id, s_ex, s_mem} = 4'hF;
          f_wb    = 1'b1;
          state_d = DMEM_WAIT;
        end else if (br_taken_ex) begin
          f_id     = 1'b1;
          f_ex     = 1'b1;
          br_flush = 1'b1;
        end else if (!imem_ack) begin
          s_if    = 1'b1;
          f_id    = 1'b1;
          state_d = IMEM_WAIT;
        end else if (lu_hazard) begin
          s_if = 1'b1;
          s_id = 1'b1;
          f_ex = 1'b1;
        end
      end
      // EX is frozen here, so a taken branch is simply re-presented later.
      DMEM_WAIT: begin
        if (dmem_ack) begin
          state_d = RUN;
        end else begin
          {s_if, s_id, s_ex, s_mem} = 4'hF;
          f_wb = 1'b1;
          if (expire) begin
            mem_err_d = 1'b1;
            state_d   = HALT;
          end
        end
      end
      IMEM_WAIT: begin
        s_if = 1'b1;
        f_id = 1'b1;
        if (imem_ack) begin
          // A fetch issued before a taken branch is stale and must be dropped.
          s_if         = 1'b0;
          f_id         = drop_fetch_q || br_taken_ex;
          f_ex         = br_taken_ex;
          br_flush     = br_taken_ex;
          drop_fetch_d = 1'b0;
          state_d      = RUN;
        end else if (expire) begin
          mem_err_d = 1'b1;
          state_d   = HALT;
        end else if (dmem_stall) begin
          {s_if, s_id, s_ex, s_mem} = 4'hF;
          f_id    = 1'b0;
          f_wb    = 1'b1;
          state_d = DMEM_WAIT;
        end else if (br_taken_ex) begin
          f_ex         = 1'b1;
          drop_fetch_d = 1'b1;
          br_flush     = 1'b1;
        end
      end
      HALT: begin
        {s_if, s_id, s_ex, s_mem} = 4'hF;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      drop_fetch_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_fetch_q <= drop_fetch_d;
      mem_err_q    <= mem_err_d;
    end
  end

  pipe_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_d != state_q),
    .en       ((state_q == DMEM_WAIT) || (state_q == IMEM_WAIT)),
    .wait_cnt (wait_cnt_unused),
    .expire   (expire)
  );

  // Outputs are held low for the whole time reset is asserted.
  assign stall_if  = rst_n && s_if;
  assign stall_id  = rst_n && s_id;
  assign stall_ex  = rst_n && s_ex;
  assign stall_mem = rst_n && s_mem;
  assign flush_id  = rst_n && f_id;
  assign flush_ex  = rst_n && f_ex;
  assign flush_wb  = rst_n && f_wb;
  assign mem_err   = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + (s_if ? CNT_W'(1) : CNT_W'(0));
    flush_count_d  = flush_count_q + (br_flush ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  logic perf_unused;
  assign perf_unused  = br_flush;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_pipeline_stall_ctrl : directed self-checking bench for the stall   |
// |                          sequencer (MAX_WAIT=4)                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lu_hazard, br_taken_ex, imem_ack, dmem_req, dmem_ack;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_wb, mem_err;
  logic [31:0] stall_cycles, flush_count;
  logic [7:0]  outs;

  int total = 0;
  int bad   = 0;

  pipeline_stall_ctrl #(
    .MAX_WAIT (4),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lu_hazard    (lu_hazard),
    .br_taken_ex  (br_taken_ex),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .flush_wb     (flush_wb),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  // Bit order: stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_wb mem_err
  assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, mem_err};

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic drive(input logic lu, input logic br, input logic ia,
                       input logic dr, input logic da);
    lu_hazard   = lu;
    br_taken_ex = br;
    imem_ack    = ia;
    dmem_req    = dr;
    dmem_ack    = da;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    total++;
    assert (outs === exp)
      else begin
        bad++;
        $error("FAIL %s: outs got %b want %b", tag, outs, exp);
      end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1, 0, 1, 0);
    chk("reset_outs", 8'h00);
    chk_cnt("reset_stall_cycles", stall_cycles, 32'd0);
    chk_cnt("reset_flush_count", flush_count, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0);
    chk("idle_after_reset", 8'h00);
    tick();

    // load-use bubble for one cycle only
    drive(1, 0, 1, 0, 0);
    chk("lu_bubble", 8'hC4);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("lu_next_idle", 8'h00);
    tick();

    // branch overrides load-use
    drive(1, 1, 1, 0, 0);
    chk("lu_with_branch", 8'h0C);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("branch_next_idle", 8'h00);
    chk_cnt("flush_count_1", flush_count, perf(32'd1));
    tick();

    // dmem wait: three stalled cycles, ack releases
    drive(0, 0, 1, 1, 0);
    chk("dmem_enter", 8'hF2);
    tick();
    drive(0, 1, 1, 1, 0);
    chk("dmem_wait1_br_ignored", 8'hF2);
    tick();
    drive(0, 0, 1, 1, 0);
    chk("dmem_wait2", 8'hF2);
    tick();
    drive(0, 0, 1, 1, 1);
    chk("dmem_ack_cycle", 8'h00);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("dmem_back_run", 8'h00);
    chk_cnt("flush_count_dmem", flush_count, perf(32'd1));
    tick();

    // imem wait with branch on 2nd cycle; ack lands exactly on the limit
    drive(0, 0, 0, 0, 0);
    chk("imem_enter", 8'h88);
    tick();
    drive(0, 1, 0, 0, 0);
    chk("imem_branch", 8'h8C);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("imem_wait3", 8'h88);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("imem_wait4", 8'h88);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("imem_ack_drop", 8'h08);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("imem_back_run_no_err", 8'h00);
    chk_cnt("stall_cycles_8", stall_cycles, perf(32'd8));
    chk_cnt("flush_count_2", flush_count, perf(32'd2));
    tick();

    // dmem preempting imem wait keeps the drop flag
    drive(0, 0, 0, 0, 0);
    chk("pre_imem_enter", 8'h88);
    tick();
    drive(0, 1, 0, 0, 0);
    chk("pre_imem_branch", 8'h8C);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("pre_dmem_preempt", 8'hF2);
    tick();
    drive(0, 0, 0, 1, 1);
    chk("pre_dmem_ack", 8'h00);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("pre_imem_reenter", 8'h88);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("pre_drop_retained", 8'h08);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("pre_back_run", 8'h00);
    tick();

    // timeout: dmem never acks
    drive(0, 0, 1, 1, 0);
    chk("to_enter", 8'hF2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait", 8'hF2);
    end
    tick();
    drive(0, 0, 1, 0, 0);
    chk("halt_idle", 8'hF1);
    tick();
    drive(1, 1, 0, 1, 1);
    chk("halt_sticky", 8'hF1);
    rst_n = 1'b0;
    #1;
    chk("halt_reset", 8'h00);
    chk_cnt("halt_reset_cnt", stall_cycles, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0);
    chk("halt_reset_run", 8'h00);
    tick();

    // reset in the middle of an imem wait with drop_fetch set
    drive(0, 0, 0, 0, 0);
    chk("mid_imem_enter", 8'h88);
    tick();
    drive(0, 1, 0, 0, 0);
    chk("mid_imem_branch", 8'h8C);
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("mid_reset_outs", 8'h00);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0);
    chk("mid_release_run", 8'h00);
    chk_cnt("mid_flush_count", flush_count, 32'd0);
    chk_cnt("mid_stall_cycles", stall_cycles, 32'd0);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("mid_idle", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
